mem_bus_arbiter: RTL

//  Shares the Slipstream memory bus between NREQ bus masters (0=CPU, 1=blitter, 2=DSP).

---
 rtl/mem_bus_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: one-hot grant, hold until DONE/withdraw/timeout, one turnaround cycle.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority with index 0 highest.
module mem_bus_arbiter #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    MasterClock,
    input  logic                    RESETL,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         LOCK,
    input  logic                    DONE,
    output logic [NREQ-1:0]         GNT,
    output logic [$clog2(NREQ)-1:0] GNT_ID,
    output logic                    BUSY,
    output logic                    TIMEOUT_ERR
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_TURN
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IDW-1:0]  gnt_id_q;
    logic            busy_q;
    logic            terr_q;
    logic [CW-1:0]   cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]  last_q;
`endif

    logic            win_vld_d;
    logic [IDW-1:0]  win_idx_d;
    logic [IDW-1:0]  cand;
    logic            own_req;
    logic            own_lock;
    logic            at_limit;
    logic            timeout_hit;
    logic            release_own;

    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            cand = IDW'((int'(last_q) + 1 + k) % NREQ);
`else
            cand = IDW'(k);
`endif
            if (!win_vld_d && REQ[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
    end

    // DONE on the timeout boundary takes precedence over the forced release.
    assign own_req     = REQ[gnt_id_q];
    assign own_lock    = LOCK[gnt_id_q];
    assign at_limit    = (cnt_q == CW'(TIMEOUT - 1));
    assign timeout_hit = at_limit & ~DONE;
    assign release_own = (DONE & ~own_lock) | ~own_req | timeout_hit;

    always_ff @(posedge MasterClock or negedge RESETL) begin
        if (!RESETL) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= IDW'(NREQ - 1);
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    terr_q <= 1'b0;
                    if (win_vld_d) begin
                        state_q  <= ST_OWN;
                        gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx_d;
                        gnt_id_q <= win_idx_d;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end
                ST_OWN: begin
                    if (release_own) begin
                        state_q <= ST_TURN;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        terr_q  <= timeout_hit;
                        cnt_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q  <= gnt_id_q;
`endif
                    end else if (DONE) begin
                        cnt_q <= '0;
                    end else if (cnt_q != {CW{1'b1}}) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_TURN: begin
                    state_q <= ST_IDLE;
                    terr_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    terr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign GNT         = gnt_q;
    assign GNT_ID      = gnt_id_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = terr_q;

endmodule
